// File: rtl/byte_pack_pkg.sv
// rtl/byte_pack_pkg.sv - shared types and lane-mask helper for the byte-to-word packer
package byte_pack_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    typedef logic [1:0] lane_cnt_t;
    typedef logic [3:0] keep_t;

    // Mask covering lanes 0..c inclusive.
    function automatic keep_t keep_from_cnt(input lane_cnt_t c);
        keep_t k;
        case (c)
            2'd0:    k = 4'b0001;
            2'd1:    k = 4'b0011;
            2'd2:    k = 4'b0111;
            default: k = 4'b1111;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// rtl/pack_out_reg.sv - registered word output stage with valid/ready hold
module pack_out_reg
    import byte_pack_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              load,
    input  logic [WORD_W-1:0] load_data,
    input  keep_t             load_keep,
    input  logic              load_last,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [WORD_W-1:0] out_data,
    output keep_t             out_keep,
    output logic              out_last,
    output logic              free
);

    logic [WORD_W-1:0] lane_mask;

    assign free      = !out_valid || out_ready;
    assign lane_mask = {{8{load_keep[3]}}, {8{load_keep[2]}},
                        {8{load_keep[1]}}, {8{load_keep[0]}}};

    // Load may only arrive while free, so a stalled word is never overwritten.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= load_data & lane_mask;
            out_keep  <= load_keep;
            out_last  <= load_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs a byte stream into 32-bit little-endian words; PACKER_IDLE_FLUSH_EN enables idle flush
module byte_word_packer
    import byte_pack_pkg::*;
#(
    parameter int IDLE_CYCLES = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output keep_t             out_keep,
    output logic              out_last
);

    if (IDLE_CYCLES < 1 || IDLE_CYCLES > 255) begin : g_bad_idle_cycles
        $error("IDLE_CYCLES must be in 1..255");
    end

    logic [23:0]       acc;
    lane_cnt_t         cnt;
    logic              free;
    logic              accept;
    logic              complete;
    logic              flush;
    logic              load;
    logic [WORD_W-1:0] word;
    logic [WORD_W-1:0] load_data;
    keep_t             load_keep;
    logic              load_last;

    assign in_ready = free;
    assign accept   = in_valid && free;
    assign complete = accept && (cnt == 2'd3 || in_last);
    assign load     = complete || flush;

    always_comb begin
        word = {8'h00, acc};
        case (cnt)
            2'd0:    word[7:0]   = in_data;
            2'd1:    word[15:8]  = in_data;
            2'd2:    word[23:16] = in_data;
            default: word[31:24] = in_data;
        endcase
    end

    // A completing byte wins; otherwise the load is an idle flush of the held lanes.
    always_comb begin
        load_data = word;
        load_keep = keep_from_cnt(cnt);
        load_last = in_last;
        if (!complete) begin
            load_data = {8'h00, acc};
            load_keep = keep_from_cnt(cnt - 2'd1);
            load_last = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            acc <= '0;
            cnt <= '0;
        end else if (accept) begin
            if (complete) begin
                acc <= '0;
                cnt <= '0;
            end else begin
                acc <= word[23:0];
                cnt <= cnt + 2'd1;
            end
        end else if (flush) begin
            acc <= '0;
            cnt <= '0;
        end
    end

`ifdef PACKER_IDLE_FLUSH_EN
    localparam logic [7:0] IDLE_LIMIT = 8'(IDLE_CYCLES);

    logic [7:0] idle_cnt;
    logic       idle_hit;

    assign idle_hit = (idle_cnt == IDLE_LIMIT);
    assign flush    = idle_hit && free && !accept && (cnt != 2'd0);

    // Saturates at the limit so a flush blocked by backpressure stays armed.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            idle_cnt <= '0;
        end else if (accept || cnt == 2'd0 || flush) begin
            idle_cnt <= '0;
        end else if (!idle_hit) begin
            idle_cnt <= idle_cnt + 8'd1;
        end
    end
`else
    assign flush = 1'b0;
`endif

    pack_out_reg u_out_reg (
        .clk       (clk),
        .resetn    (resetn),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .load_last (load_last),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .free      (free)
    );

endmodule

// File: tb/tb_byte_word_packer.sv
// tb/tb_byte_word_packer.sv - scoreboard bench for byte_word_packer
module tb_byte_word_packer;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic [3:0]  out_keep;
    logic        out_last;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;
    logic [36:0] sb[$];

    logic        stalled = 1'b0;
    logic [36:0] held;
    logic [36:0] exp_w;
    logic        seen;
    int          first;
    int          start;
    logic [31:0] w;

    byte_word_packer #(.IDLE_CYCLES(16)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        sb.push_back({l, k, d});
    endtask

    task automatic send_byte(input logic [7:0] d, input logic l);
        logic ok;
        ok       = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
            @(posedge clk);
            #1;
        end
        if (!ok) begin
            n_vec++;
            n_err++;
            $display("FAIL send_timeout: byte %h never accepted", d);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        #1;
        check("drain_empty", 40'(sb.size()), 40'd0);
    endtask

    always @(negedge clk) begin
        if (!resetn) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check("hold_stable", 40'({out_last, out_keep, out_data}), 40'(held));
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 40'(in_ready), 40'd0);
                stalled = 1'b1;
                held    = {out_last, out_keep, out_data};
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_word: got %h keep %h last %b with nothing expected",
                             out_data, out_keep, out_last);
                end else begin
                    exp_w = sb.pop_front();
                    check("word", 40'({out_last, out_keep, out_data}), 40'(exp_w));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", 40'(out_valid), 40'd0);
        check("rst_out_data",  40'(out_data),  40'd0);
        check("rst_out_keep",  40'(out_keep),  40'd0);
        check("rst_out_last",  40'(out_last),  40'd0);
        check("rst_in_ready",  40'(in_ready),  40'd1);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // basic packing and latency
        expect_word(32'h44332211, 4'hF, 1'b0);
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        @(negedge clk);
        check("latency_pre", 40'(out_valid), 40'd0);
        @(posedge clk);
        #1;
        send_byte(8'h44, 1'b0);
        @(negedge clk);
        check("latency_post", 40'(out_valid), 40'd1);
        @(posedge clk);
        #1;

        // short packets
        expect_word(32'h0000BBAA, 4'h3, 1'b1);
        send_byte(8'hAA, 1'b0);
        send_byte(8'hBB, 1'b1);
        expect_word(32'h0000005C, 4'h1, 1'b1);
        send_byte(8'h5C, 1'b1);
        drain();

        // backpressure: stall 5 cycles once the first word appears
        expect_word(32'h04030201, 4'hF, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0);
        seen = 1'b0;
        fork
            begin
                for (int i = 1; i <= 8; i++) send_byte(8'(i), 1'b0);
            end
            begin
                for (int i = 0; i < 50 && !seen; i++) begin
                    @(posedge clk);
                    #1;
                    if (out_valid) seen = 1'b1;
                end
                check("bp_word_seen", 40'(seen), 40'd1);
                if (seen) begin
                    out_ready = 1'b0;
                    repeat (5) @(posedge clk);
                    #1;
                    out_ready = 1'b1;
                end
            end
        join
        drain();

        // back-to-back random words at full rate
        start = cyc;
        for (int n = 0; n < 100; n++) begin
            w = $urandom;
            expect_word(w, 4'hF, 1'b0);
            for (int b = 0; b < 4; b++) send_byte(w[8*b +: 8], 1'b0);
        end
        check("b2b_cycles", 40'(cyc - start), 40'd400);
        drain();

        // async reset discards a pending word
        out_ready = 1'b0;
        expect_word(32'h00000099, 4'h1, 1'b1);
        send_byte(8'h99, 1'b1);
        @(negedge clk);
        check("pend_valid", 40'(out_valid), 40'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_out_valid", 40'(out_valid), 40'd0);
        check("arst_out_data",  40'(out_data),  40'd0);
        check("arst_out_keep",  40'(out_keep),  40'd0);
        check("arst_out_last",  40'(out_last),  40'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        resetn    = 1'b1;
        out_ready = 1'b1;

        // async reset discards a partial word
        send_byte(8'h01, 1'b0);
        send_byte(8'h02, 1'b0);
        #2;
        resetn = 1'b0;
        #1;
        check("arst2_out_valid", 40'(out_valid), 40'd0);
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        expect_word(32'h40302010, 4'hF, 1'b0);
        send_byte(8'h10, 1'b0);
        send_byte(8'h20, 1'b0);
        send_byte(8'h30, 1'b0);
        send_byte(8'h40, 1'b0);
        drain();

        // idle behaviour with a partial word
        send_byte(8'h7E, 1'b0);
`ifdef PACKER_IDLE_FLUSH_EN
        expect_word(32'h00007F7E, 4'h3, 1'b0);
        send_byte(8'h7F, 1'b0);
        first = -1;
        for (int k = 1; k <= 40 && first < 0; k++) begin
            @(posedge clk);
            #1;
            if (out_valid) first = k;
        end
        check("idle_flush_clocks", 40'(first), 40'd17);
        drain();
`else
        send_byte(8'h7F, 1'b0);
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("no_idle_flush", 40'(seen), 40'd0);
        expect_word(32'h00807F7E, 4'h7, 1'b1);
        send_byte(8'h80, 1'b1);
        drain();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
